// File: rtl/pc_audio_pkg.sv
// pc_audio_pkg
//   Shared definitions for the PC-8001 audio mixer: register addresses,
//   status bit positions, mixer state encoding and a constant clog2 helper.
//   No ports (package).
package pc_audio_pkg;

    // Register map (addresses 0..NCH-1 are the per-channel volumes)
    localparam logic [3:0] ADR_MUTE   = 4'h8;
    localparam logic [3:0] ADR_MASTER = 4'h9;
    localparam logic [3:0] ADR_STAT   = 4'hA;

    // Bit positions inside the status register
    localparam int STAT_CLIP    = 0;
    localparam int STAT_OVERRUN = 1;

    // Mix sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_SCALE = 2'd2
    } mix_state_t;

    // Ceiling log2 for elaboration-time width calculations; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pc_dsm_dac.sv
// pc_dsm_dac
//   First-order delta-sigma 1-bit DAC. Every clk the unsigned input is added
//   to a W-bit accumulator; the carry out of that add is the output bit, so
//   the pulse density of dout is din / 2^W.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset (accumulator and dout clear)
//   din      in   W-bit unsigned level to convert
//   dout     out  registered bitstream
module pc_dsm_dac
    import pc_audio_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] din,
    output logic         dout
);

    logic [W-1:0] dacc;
    logic [W:0]   sum;

    assign sum = {1'b0, dacc} + {1'b0, din};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dacc <= '0;
            dout <= 1'b0;
        end else begin
            dacc <= sum[W-1:0];
            dout <= sum[W];
        end
    end

endmodule

// File: rtl/pc_audio_mixer.sv
// pc_audio_mixer
//   N-channel audio mixer for the PC-8001 I/O bus. Once every SAMPLE_DIV
//   clocks a mix pass walks the channels one per clk, accumulating
//   ch_in[i]*vol[i] for unmuted channels, then scales by the master volume,
//   saturates to OUT_W bits (setting a sticky clip flag) and feeds the result
//   to a first-order delta-sigma DAC.
// Ports:
//   clk, reset_n   system clock, asynchronous active-low reset
//   wr, adr, din   register write strobe / address / data (pre-decoded)
//   dout           registered read data for the current adr (1 clk latency)
//   ch_in          NCH unsigned IN_W-bit samples, channel i at [i*IN_W +: IN_W]
//   sample_out     mixed, saturated sample
//   sample_valid   one-clk pulse when sample_out updates
//   busy           high while a mix pass is in progress
//   dac_out        delta-sigma bitstream of sample_out
//   state_dbg      current sequencer state (mix_state_t encoding)
//
// Handshake: sample_valid is a one-cycle qualifier for sample_out with no
// ready/backpressure; a consumer must take the sample in the cycle
// sample_valid is high (sample_out then holds until the next pass anyway).
module pc_audio_mixer
    import pc_audio_pkg::*;
#(
    parameter int              NCH        = 8,
    parameter int              IN_W       = 10,
    parameter int              VOL_W      = 4,
    parameter int              OUT_W      = 16,
    parameter int              SAMPLE_DIV = 64,
    parameter logic [VOL_W-1:0] VOL_RST   = {VOL_W{1'b1}}
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                wr,
    input  logic [3:0]          adr,
    input  logic [7:0]          din,
    output logic [7:0]          dout,
    input  logic [NCH*IN_W-1:0] ch_in,
    output logic [OUT_W-1:0]    sample_out,
    output logic                sample_valid,
    output logic                busy,
    output logic                dac_out,
    output logic [1:0]          state_dbg
);

    localparam int CNT_W  = (clog2(SAMPLE_DIV) > 0) ? clog2(SAMPLE_DIV) : 1;
    localparam int IDX_W  = (clog2(NCH) > 0) ? clog2(NCH) : 1;
    // Sum of NCH products of IN_W x VOL_W bits
    localparam int ACC_W  = IN_W + VOL_W + clog2(NCH);
    localparam int PROD_W = ACC_W + VOL_W;
    // Keep at least one bit above OUT_W so the saturation test is always legal
    localparam int R_W    = (PROD_W > OUT_W) ? PROD_W : OUT_W + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCH - 1);

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [VOL_W-1:0] vol [NCH];
    logic [NCH-1:0]   mute;
    logic [VOL_W-1:0] master;
    logic             clip;
    logic             overrun;
    logic             clip_set;
    logic             overrun_set;
    logic             wr_stat;
    logic [7:0]       rd_data;

    assign wr_stat = wr && (adr == ADR_STAT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                vol[i] <= VOL_RST;
            end
            mute   <= '0;
            master <= '1;
        end else if (wr) begin
            for (int i = 0; i < NCH; i++) begin
                if (adr == 4'(i)) begin
                    vol[i] <= din[VOL_W-1:0];
                end
            end
            if (adr == ADR_MUTE) begin
                mute <= din[NCH-1:0];
            end
            if (adr == ADR_MASTER) begin
                master <= din[VOL_W-1:0];
            end
        end
    end

    // Sticky flags: a set in the same cycle as a clearing write wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clip    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            clip    <= clip_set    | (clip    & ~(wr_stat & din[STAT_CLIP]));
            overrun <= overrun_set | (overrun & ~(wr_stat & din[STAT_OVERRUN]));
        end
    end

    // Read mux; everything is zero-extended, unmapped addresses read 8'hFF.
    always_comb begin
        rd_data = 8'hFF;
        if (32'(adr) < 32'(NCH)) begin
            rd_data = '0;
            rd_data[VOL_W-1:0] = vol[adr[IDX_W-1:0]];
        end else if (adr == ADR_MUTE) begin
            rd_data = '0;
            rd_data[NCH-1:0] = mute;
        end else if (adr == ADR_MASTER) begin
            rd_data = '0;
            rd_data[VOL_W-1:0] = master;
        end else if (adr == ADR_STAT) begin
            rd_data = '0;
            rd_data[STAT_CLIP]    = clip;
            rd_data[STAT_OVERRUN] = overrun;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout <= '0;
        end else begin
            dout <= rd_data;
        end
    end

    // ------------------------------------------------------------------
    // Sample-rate divider
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt;
    logic             strobe;

    assign strobe = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else begin
            cnt <= strobe ? '0 : cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Mix sequencer
    // ------------------------------------------------------------------
    mix_state_t       state;
    mix_state_t       state_d;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_d;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_d;
    logic             busy_d;
    logic             valid_d;
    logic [OUT_W-1:0] sample_d;
    logic [IN_W-1:0]  ch_cur;
    logic [ACC_W-1:0] term;
    logic [PROD_W-1:0] prod;
    logic [R_W-1:0]   r;

    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d     = state;
        acc_d       = acc;
        idx_d       = idx;
        busy_d      = busy;
        valid_d     = 1'b0;
        sample_d    = sample_out;
        clip_set    = 1'b0;
        overrun_set = 1'b0;

        // Channel sample and volume are taken live in the channel's own cycle,
        // so register writes land even in the middle of a pass.
        ch_cur = ch_in[int'(idx) * IN_W +: IN_W];
        term   = mute[idx] ? {ACC_W{1'b0}} : ACC_W'(ch_cur) * ACC_W'(vol[idx]);
        prod   = PROD_W'(acc) * PROD_W'(master);
        r      = R_W'(prod >> VOL_W);

        case (state)
            ST_IDLE: begin
                if (strobe) begin
                    state_d = ST_ACC;
                    acc_d   = '0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_ACC: begin
                acc_d = acc + term;
                if (idx == IDX_LAST) begin
                    state_d = ST_SCALE;
                end else begin
                    idx_d = idx + 1'b1;
                end
            end
            ST_SCALE: begin
                if (|r[R_W-1:OUT_W]) begin
                    sample_d = '1;
                    clip_set = 1'b1;
                end else begin
                    sample_d = r[OUT_W-1:0];
                end
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // A strobe that arrives while a pass is still running is dropped.
        if (strobe && (state != ST_IDLE)) begin
            overrun_set = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc          <= '0;
            idx          <= '0;
            busy         <= 1'b0;
            sample_valid <= 1'b0;
            sample_out   <= '0;
        end else begin
            acc          <= acc_d;
            idx          <= idx_d;
            busy         <= busy_d;
            sample_valid <= valid_d;
            sample_out   <= sample_d;
        end
    end

    // ------------------------------------------------------------------
    // Delta-sigma DAC on the mixed sample
    // ------------------------------------------------------------------
    pc_dsm_dac #(
        .W (OUT_W)
    ) u_dac (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (sample_out),
        .dout    (dac_out)
    );

endmodule

// File: tb/tb_pc_audio_mixer.sv
// tb_pc_audio_mixer
//   Self-checking bench for pc_audio_mixer. Main instance uses the default
//   parameters; a second instance with SAMPLE_DIV=4 exercises overrun.
//   Expected samples come from a plain-arithmetic model of the mixing rule.
module tb_pc_audio_mixer;
    import pc_audio_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT ----------------
    logic        wr = 1'b0;
    logic [3:0]  adr = 4'h0;
    logic [7:0]  din = 8'h00;
    logic [7:0]  dout;
    logic [79:0] ch_in = '0;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        busy;
    logic        dac_out;
    logic [1:0]  state_dbg;

    pc_audio_mixer u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr           (wr),
        .adr          (adr),
        .din          (din),
        .dout         (dout),
        .ch_in        (ch_in),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .busy         (busy),
        .dac_out      (dac_out),
        .state_dbg    (state_dbg)
    );

    // ---------------- overrun DUT (SAMPLE_DIV=4) ----------------
    logic        wr2 = 1'b0;
    logic [3:0]  adr2 = ADR_STAT;
    logic [7:0]  din2 = 8'h00;
    logic [7:0]  dout2;
    logic [79:0] ch_in2 = '0;
    logic [15:0] sample_out2;
    logic        sample_valid2;
    logic        busy2;
    logic        dac_out2;
    logic [1:0]  state_dbg2;

    pc_audio_mixer #(.SAMPLE_DIV(4)) u_ovr (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr           (wr2),
        .adr          (adr2),
        .din          (din2),
        .dout         (dout2),
        .ch_in        (ch_in2),
        .sample_out   (sample_out2),
        .sample_valid (sample_valid2),
        .busy         (busy2),
        .dac_out      (dac_out2),
        .state_dbg    (state_dbg2)
    );

    // ---------------- scoreboard / model state ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];

    int         ch_m [8];
    int         vol_m [8];
    logic [7:0] mute_m;
    int         master_m;
    bit         clip_m;
    bit         ovr_m;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) vol_m[i] = 15;
        mute_m   = 8'h00;
        master_m = 15;
        clip_m   = 1'b0;
        ovr_m    = 1'b0;
    endtask

    task automatic apply_ch();
        for (int i = 0; i < 8; i++) ch_in[i*10 +: 10] = 10'(ch_m[i]);
    endtask

    // Hold reset for two edges, release 1 time unit after a rising edge.
    task automatic do_reset();
        wr = 1'b0;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic reg_write(input logic [3:0] a, input logic [7:0] d);
        adr = a;
        din = d;
        wr  = 1'b1;
        tick();
        wr  = 1'b0;
        if (a < 4'd8) vol_m[a] = int'(d & 8'h0F);
        else if (a == ADR_MUTE) mute_m = d;
        else if (a == ADR_MASTER) master_m = int'(d & 8'h0F);
        else if (a == ADR_STAT) begin
            if (d[0]) clip_m = 1'b0;
            if (d[1]) ovr_m = 1'b0;
        end
    endtask

    task automatic reg_read(input logic [3:0] a, output logic [7:0] d);
        adr = a;
        tick();
        d = dout;
    endtask

    task automatic wait_sample(output logic [15:0] s, output bit ok);
        ok = 1'b0;
        s  = '0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (sample_valid) begin
                s  = sample_out;
                ok = 1'b1;
                return;
            end
        end
    endtask

    // ---------------- reference model ----------------
    // Sum of unmuted ch*vol, times master, divided by 2^VOL_W, saturated.
    function automatic logic [15:0] model_mix(output bit clipped);
        longint sum;
        longint r;
        sum = 0;
        for (int i = 0; i < 8; i++)
            if (!mute_m[i]) sum += longint'(ch_m[i]) * longint'(vol_m[i]);
        r = (sum * longint'(master_m)) / 16;
        clipped = (r > 65535);
        return clipped ? 16'hFFFF : 16'(r);
    endfunction

    function automatic logic [7:0] model_read(input int a);
        if (a < 8) return 8'(vol_m[a]);
        if (a == 8) return mute_m;
        if (a == 9) return 8'(master_m);
        if (a == 10) return {6'b0, ovr_m, clip_m};
        return 8'hFF;
    endfunction

    task automatic check_sample(input string name);
        logic [15:0] s;
        logic [15:0] e;
        bit ok;
        wait_sample(s, ok);
        e = exp_q.pop_front();
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: no sample_valid within 200 cycles, required sample %0d", name, e);
        end else if (s !== e) begin
            n_err++;
            $display("FAIL %s: sample_out=%0d required %0d", name, s, e);
        end
    endtask

    task automatic check_read(input string name, input logic [3:0] a, input logic [7:0] e);
        logic [7:0] d;
        reg_read(a, d);
        n_vec++;
        if (d !== e) begin
            n_err++;
            $display("FAIL %s: dout[adr=%h]=%h required %h", name, a, d, e);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        ch_in   = '0;
        reset_n = 1'b0;
        #1;
        n_vec += 5;
        if (sample_out !== 16'd0) begin n_err++; $display("FAIL reset_sample: %0d required 0", sample_out); end
        if (dac_out !== 1'b0) begin n_err++; $display("FAIL reset_dac: %b required 0", dac_out); end
        if (dout !== 8'h00) begin n_err++; $display("FAIL reset_dout: %h required 00", dout); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: %b required 0", busy); end
        if (sample_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: %b required 0", sample_valid); end
        do_reset();
        check_read("reset_vol0",   4'h0, 8'h0F);
        check_read("reset_master", 4'h9, 8'h0F);
        check_read("reset_mute",   4'h8, 8'h00);
        check_read("reset_status", 4'hA, 8'h00);
        check_read("reset_unmapped", 4'hF, 8'hFF);
    endtask

    // ch0=100 at default volumes: 100*15*15/16 = 1406. The divider hits its
    // last count 63 edges after release, so busy rises at edge 64 and the
    // sample arrives 10 cycles after the strobe cycle, at edge 73.
    task automatic test_basic_mix();
        int busy_at;
        int valid_at;
        logic [15:0] s;
        bit clipped;
        logic [15:0] e;
        for (int i = 0; i < 8; i++) ch_m[i] = 0;
        ch_m[0] = 100;
        apply_ch();
        do_reset();
        e = model_mix(clipped);
        busy_at  = -1;
        valid_at = -1;
        s = '0;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (busy && busy_at < 0) busy_at = k;
            if (sample_valid) begin
                valid_at = k;
                s = sample_out;
                break;
            end
        end
        n_vec += 4;
        if (busy_at != 64) begin n_err++; $display("FAIL basic_busy_edge: %0d required 64", busy_at); end
        if (valid_at != 73) begin n_err++; $display("FAIL basic_latency: %0d required 73", valid_at); end
        if (s !== e) begin n_err++; $display("FAIL basic_sample_model: %0d required %0d", s, e); end
        if (s !== 16'd1406) begin n_err++; $display("FAIL basic_sample: %0d required 1406", s); end
    endtask

    // Runs right after a sample, so the next pass sees every write.
    task automatic test_mute_volume();
        bit clipped;
        reg_write(4'h0, 8'h08);
        exp_q.push_back(model_mix(clipped));
        check_sample("vol_model");
        n_vec++;
        if (sample_out !== 16'd750) begin n_err++; $display("FAIL vol_sample: %0d required 750", sample_out); end
        reg_write(ADR_MUTE, 8'h01);
        exp_q.push_back(16'd0);
        check_sample("mute_sample");
        check_read("mute_readback", ADR_MUTE, 8'h01);
        check_read("vol_readback", 4'h0, 8'h08);
    endtask

    task automatic test_clip();
        bit seen;
        for (int i = 0; i < 8; i++) ch_m[i] = 1023;
        apply_ch();
        do_reset();
        exp_q.push_back(16'hFFFF);
        check_sample("clip_sample");
        check_read("clip_status", ADR_STAT, 8'h01);
        reg_write(ADR_STAT, 8'h01);
        check_read("clip_cleared", ADR_STAT, 8'h00);
        // Clearing write in the very cycle the pass saturates: set must win.
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (state_dbg == ST_SCALE) begin
                seen = 1'b1;
                break;
            end
        end
        adr = ADR_STAT;
        din = 8'h01;
        wr  = 1'b1;
        tick();
        wr  = 1'b0;
        n_vec += 2;
        if (!seen) begin n_err++; $display("FAIL clip_scale_wait: SCALE state not reached, required within 200 cycles"); end
        if (sample_valid !== 1'b1) begin n_err++; $display("FAIL clip_coincident_valid: %b required 1", sample_valid); end
        check_read("clip_set_wins", ADR_STAT, 8'h01);
    endtask

    // 512*8 on all channels = 32768; *8 /16 = 16384 = a quarter of full scale.
    task automatic test_dac();
        logic bits [64];
        int win;
        int ones;
        bit clipped;
        for (int i = 0; i < 8; i++) ch_m[i] = 512;
        apply_ch();
        do_reset();
        for (int i = 0; i < 8; i++) reg_write(4'(i), 8'h08);
        reg_write(ADR_MASTER, 8'h08);
        exp_q.push_back(model_mix(clipped));
        check_sample("dac_level_sample");
        tick();
        tick();
        for (int k = 0; k < 64; k++) begin
            bits[k] = dac_out;
            tick();
        end
        for (int w = 0; w < 16; w++) begin
            win = 0;
            for (int j = 0; j < 4; j++) win += int'(bits[w*4+j]);
            n_vec++;
            if (win != 1) begin n_err++; $display("FAIL dac_quarter_window%0d: %0d ones required 1", w, win); end
        end
        reg_write(ADR_MUTE, 8'hFF);
        exp_q.push_back(16'd0);
        check_sample("dac_zero_sample");
        tick();
        tick();
        ones = 0;
        for (int k = 0; k < 40; k++) begin
            ones += int'(dac_out);
            tick();
        end
        n_vec++;
        if (ones != 0) begin n_err++; $display("FAIL dac_zero: %0d ones required 0", ones); end
    endtask

    task automatic test_random();
        logic [15:0] s;
        bit ok;
        bit clipped;
        int a;
        do_reset();
        wait_sample(s, ok);
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < 8; i++) begin
                ch_m[i] = (it % 4 == 3) ? int'($urandom_range(900, 1023)) : int'($urandom_range(0, 1023));
                reg_write(4'(i), 8'($urandom_range(0, 255)));
            end
            reg_write(ADR_MUTE, 8'($urandom_range(0, 255) & $urandom_range(0, 255)));
            reg_write(ADR_MASTER, 8'($urandom_range(0, 255)));
            apply_ch();
            exp_q.push_back(model_mix(clipped));
            if (clipped) clip_m = 1'b1;
            check_sample("rand_sample");
            check_read("rand_status", ADR_STAT, {6'b0, ovr_m, clip_m});
            a = int'($urandom_range(0, 15));
            check_read("rand_readback", 4'(a), model_read(a));
            if (clip_m) reg_write(ADR_STAT, 8'h01);
        end
    endtask

    // SAMPLE_DIV=4: strobes after edges 3 and 7; the second finds the pass
    // still running, sets overrun at edge 8, visible on dout2 after edge 9.
    task automatic test_overrun();
        int at;
        do_reset();
        at = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (dout2[STAT_OVERRUN] === 1'b1) begin
                at = k;
                break;
            end
        end
        n_vec += 2;
        if (at != 9) begin n_err++; $display("FAIL overrun_edge: %0d required 9", at); end
        if (dout2 !== 8'h02) begin n_err++; $display("FAIL overrun_status: %h required 02", dout2); end
    endtask

    task automatic test_reset_mid_acc();
        int valids;
        bit seen;
        for (int i = 0; i < 8; i++) ch_m[i] = int'($urandom_range(1, 1023));
        apply_ch();
        do_reset();
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (busy) begin
                seen = 1'b1;
                break;
            end
        end
        tick();
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        n_vec += 4;
        if (!seen) begin n_err++; $display("FAIL midreset_busy_wait: busy never rose, required within 200 cycles"); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy: %b required 0", busy); end
        if (sample_valid !== 1'b0) begin n_err++; $display("FAIL midreset_valid: %b required 0", sample_valid); end
        if (state_dbg !== ST_IDLE) begin n_err++; $display("FAIL midreset_state: %0d required 0", state_dbg); end
        tick();
        reset_n = 1'b1;
        model_reset();
        valids = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            valids += int'(sample_valid);
        end
        n_vec++;
        if (valids != 0) begin n_err++; $display("FAIL midreset_no_valid: %0d pulses required 0", valids); end
        check_read("midreset_status", ADR_STAT, 8'h00);
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_basic_mix();
        test_mute_volume();
        test_clip();
        test_dac();
        test_random();
        test_overrun();
        test_reset_mid_acc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pc_audio_mixer.md
Name: pc_audio_mixer

Overview:
- Parametrised N-channel audio mixer with a CPU-programmable register file and a first-order delta-sigma 1-bit DAC.
- Replaces the fixed-sum PSG/8253/beep adder and inline delta-sigma loop in the PC-8001 top level.
- Adds per-channel volume, per-channel mute, master volume, saturation with a sticky clip flag, and an internal sample-rate divider.
- Sits on the CPU I/O bus. The integrator decodes the port range and drives `wr` and `adr`.

Parameters:
- NCH, 8, number of input channels, 1..8.
- IN_W, 10, width of each unsigned channel input.
- VOL_W, 4, volume register width, 1..8.
- OUT_W, 16, width of the mixed sample and of the DAC accumulator.
- SAMPLE_DIV, 64, clk cycles per mix sample. Must be >= NCH+3 for overrun-free operation.
- VOL_RST, {VOL_W{1'b1}}, reset value of the channel volume registers.

Ports:
- clk  in  1  system clock (14.31818 MHz in PC-8001 builds).
- reset_n  in  1  asynchronous, active-low reset.
- wr  in  1  register write strobe, one clk wide, already qualified by iorq and port decode.
- adr  in  4  register address.
- din  in  8  write data.
- dout  out  8  registered read data for the current `adr`.
- ch_in  in  NCH*IN_W  unsigned channel samples; channel i is at [i*IN_W +: IN_W].
- sample_out  out  OUT_W  mixed, saturated sample.
- sample_valid  out  1  one-clk pulse when `sample_out` updates.
- busy  out  1  high while a mix pass is in progress.
- dac_out  out  1  delta-sigma bitstream.

Behaviour:
- Reset (async): all outputs and `cnt` clear to 0; registers take the values below.
  - Outputs: `sample_out`=0, `sample_valid`=0, `busy`=0, `dac_out`=0, `dout`=0.
  - Registers: vol[*]=VOL_RST, mute=0, master=all ones, clip=0, overrun=0, divider=0, DSM accumulator=0.
  - State machine enters IDLE. Reset during a mix pass abandons it; no `sample_valid` is produced.
- Register map:
  - 0..NCH-1: vol[i], written from din[VOL_W-1:0].
  - 8: mute mask, written from din[NCH-1:0].
  - 9: master volume, written from din[VOL_W-1:0].
  - A: status. Read returns {6'b0, overrun, clip}. A write with bit0=1 clears clip; bit1=1 clears overrun.
  - Other addresses, and vol addresses >= NCH: reads return 8'hFF, writes are ignored.
  - Read data is zero-extended.
- Read timing: `dout` is registered every clk from the current `adr` (1-cycle latency).
- Divider:
  - Counts 0..SAMPLE_DIV-1. `strobe` is high for one cycle when the count equals SAMPLE_DIV-1.
  - First strobe occurs SAMPLE_DIV cycles after reset release.
- FSM states: IDLE, ACC, SCALE.
  - IDLE: on strobe, go to ACC with acc=0, idx=0, busy=1.
  - ACC: one channel per clk.
    - acc += mute[idx] ? 0 : ch_in[idx]*vol[idx].
    - `ch_in` and vol[idx] are sampled in that channel's cycle. Register writes take effect immediately, even mid-pass.
    - After idx=NCH-1, go to SCALE.
  - SCALE: r = (acc*master) >> VOL_W.
    - If r > 2^OUT_W-1, `sample_out` = all ones and clip=1; otherwise `sample_out` = r[OUT_W-1:0].
    - `sample_valid`=1 for one cycle, busy=0, return to IDLE.
- Widths:
  - acc is IN_W+VOL_W+clog2(NCH) bits.
  - The product with master is VOL_W wider, so no internal overflow is possible.
- Latency: strobe seen at edge t → `sample_valid` high in cycle t+NCH+2 (t+10 for NCH=8).
- Overrun: a strobe while not IDLE is ignored and sets overrun=1.
- Sticky flag priority: when a set and a clearing write occur in the same cycle, set wins.
- Delta-sigma DAC:
  - Every clk: {carry, dacc} = dacc + sample_out, using an OUT_W-bit accumulator.
  - `dac_out` <= carry.
  - The pulse density equals sample_out / 2^OUT_W.

Decomposition:
- Package `pc_audio_pkg`: register address constants (ADR_MUTE=8, ADR_MASTER=9, ADR_STAT=A), status bit indices, FSM state enum, clog2 function.
- Sub-module `pc_dsm_dac`: parameter W, ports clk, reset_n, din[W-1:0], dout. Holds the first-order accumulator. The mixer instantiates it on `sample_out`.

Test Plan (NCH=8, IN_W=10, VOL_W=4, OUT_W=16, SAMPLE_DIV=64 unless stated):
- Reset defaults: after reset, reading adr 0 → 8'h0F, adr 9 → 8'h0F, adr 8 → 0, adr A → 0, adr F → FF. `sample_out`=0, `dac_out`=0.
- Basic mix: ch0=100, other channels 0, default volumes → acc=1500, r=22500>>4=1406. `sample_valid` pulses exactly 10 cycles after strobe with `sample_out`=1406.
- Mute and volume: write vol[0]=8, mix ch0=100 → 750. Write mute=8'h01 → `sample_out`=0 on the next sample.
- Clip: all channels 1023 → r=115087 → `sample_out`=65535 and status reads 8'h01. Write 8'h01 to adr A → status 0. Repeat with a clear write coincident with SCALE → clip stays 1.
- DAC: force `sample_out`=16384 steady → `dac_out` is high exactly 1 in every 4 clk. `sample_out`=0 → `dac_out` stays 0.
- Overrun and reset: SAMPLE_DIV=4 → status bit1 set within 8 cycles. Deassert reset_n mid-ACC → `busy`=0, no `sample_valid`, status=0.
